decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/regfile.sv | 33 +++
 rtl/decode_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I decode constants, encodings and immediate helper
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_PASSB = 4'd9
    } alu_ctl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U
    } imm_sel_t;

    // Reassemble and sign-extend the immediate scattered across the instruction word.
    function automatic logic [31:0] imm_extend(input logic [31:0] instr, input imm_sel_t sel);
        case (sel)
            IMM_I:   return {{20{instr[31]}}, instr[31:20]};
            IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   return {instr[31:12], 12'b0};
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, x0 hardwired to zero, write-through read ports
module regfile
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [0:31];

    // Clear every register on reset; otherwise write unless the target is x0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // A read of the register being written this cycle sees the new value.
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : ((we && (wa == ra1)) ? wd : regs[ra1]);
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : ((we && (wa == ra2)) ? wd : regs[ra2]);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: control decode, branch resolve, D/E register
module decode_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        ForwardAD,
    input  logic        ForwardBD,
    input  logic [31:0] ALUResultM,
    input  logic        FlushE,
    output logic [31:0] PCBranchD,
    output logic        BranchD,
    output logic        PCSrcD,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [3:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        IllegalE
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;

    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    result_src_t result_src;
    alu_ctl_t    alu_ctl;
    imm_sel_t    imm_sel;
    logic        jal;
    logic        jalr;
    logic        illegal;
    logic        br_cond;

    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] imm_ext;
    logic [31:0] pc_d;
    logic [31:0] jalr_sum;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign funct7 = InstrD[31:25];
    assign rd     = InstrD[11:7];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (RegWriteW),
        .wa    (RdW),
        .wd    (ResultW),
        .ra1   (Rs1D),
        .ra2   (Rs2D),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Main decoder; any unsupported encoding drops every control bit and flags illegal.
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        result_src = RES_ALU;
        alu_ctl    = ALU_ADD;
        imm_sel    = IMM_NONE;
        BranchD    = 1'b0;
        jal        = 1'b0;
        jalr       = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  alu_ctl = ALU_ADD;
                        3'b001:  alu_ctl = ALU_SLL;
                        3'b010:  alu_ctl = ALU_SLT;
                        3'b100:  alu_ctl = ALU_XOR;
                        3'b101:  alu_ctl = ALU_SRL;
                        3'b110:  alu_ctl = ALU_OR;
                        3'b111:  alu_ctl = ALU_AND;
                        default: illegal = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    case (funct3)
                        3'b000:  alu_ctl = ALU_SUB;
                        3'b101:  alu_ctl = ALU_SRA;
                        default: illegal = 1'b1;
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_sel   = IMM_I;
                case (funct3)
                    3'b000:  alu_ctl = ALU_ADD;
                    3'b010:  alu_ctl = ALU_SLT;
                    3'b100:  alu_ctl = ALU_XOR;
                    3'b110:  alu_ctl = ALU_OR;
                    3'b111:  alu_ctl = ALU_AND;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
                imm_sel    = IMM_I;
                illegal    = (funct3 != 3'b010);
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_sel   = IMM_S;
                illegal   = (funct3 != 3'b010);
            end
            OP_BRANCH: begin
                BranchD = 1'b1;
                alu_ctl = ALU_SUB;
                imm_sel = IMM_B;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                jal        = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_PC4;
                imm_sel    = IMM_J;
            end
            OP_JALR: begin
                jalr       = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_PC4;
                imm_sel    = IMM_I;
                illegal    = (funct3 != 3'b000);
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = ALU_PASSB;
                imm_sel   = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            alu_src    = 1'b0;
            result_src = RES_ALU;
            alu_ctl    = ALU_ADD;
            imm_sel    = IMM_NONE;
            BranchD    = 1'b0;
            jal        = 1'b0;
            jalr       = 1'b0;
        end
    end

    assign imm_ext = imm_extend(InstrD, imm_sel);

    // Branch compare and JALR base take the M-stage result when the hazard unit forwards.
    assign src_a = ForwardAD ? ALUResultM : rd1;
    assign src_b = ForwardBD ? ALUResultM : rd2;

    // Evaluate the branch condition selected by funct3.
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (src_a == src_b);
            3'b001:  br_cond = (src_a != src_b);
            3'b100:  br_cond = ($signed(src_a) <  $signed(src_b));
            3'b101:  br_cond = ($signed(src_a) >= $signed(src_b));
            3'b110:  br_cond = (src_a <  src_b);
            3'b111:  br_cond = (src_a >= src_b);
            default: br_cond = 1'b0;
        endcase
    end

    assign pc_d      = PCPlus4D - 32'd4;
    assign jalr_sum  = src_a + imm_ext;
    assign PCBranchD = jalr ? {jalr_sum[31:1], 1'b0} : (pc_d + imm_ext);
    assign PCSrcD    = (BranchD & br_cond) | jal | jalr;

    // D/E pipeline register; reset and flush both load an all-zero bubble.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCPlus4E    <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            IllegalE    <= 1'b0;
        end else begin
            RegWriteE   <= reg_write;
            MemWriteE   <= mem_write;
            ALUSrcE     <= alu_src;
            ResultSrcE  <= result_src;
            ALUControlE <= alu_ctl;
            RD1E        <= rd1;
            RD2E        <= rd2;
            ImmExtE     <= imm_ext;
            PCPlus4E    <= PCPlus4D;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= rd;
            IllegalE    <= illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - table-driven self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        ForwardAD;
    logic        ForwardBD;
    logic [31:0] ALUResultM;
    logic        FlushE;
    logic [31:0] PCBranchD;
    logic        BranchD;
    logic        PCSrcD;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCPlus4E;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic        IllegalE;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [32];

    decode_stage dut (
        .clk         (clk),
        .reset       (reset),
        .InstrD      (InstrD),
        .PCPlus4D    (PCPlus4D),
        .RegWriteW   (RegWriteW),
        .RdW         (RdW),
        .ResultW     (ResultW),
        .ForwardAD   (ForwardAD),
        .ForwardBD   (ForwardBD),
        .ALUResultM  (ALUResultM),
        .FlushE      (FlushE),
        .PCBranchD   (PCBranchD),
        .BranchD     (BranchD),
        .PCSrcD      (PCSrcD),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCPlus4E    (PCPlus4E),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .IllegalE    (IllegalE)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        fwa;
        logic        fwb;
        logic [31:0] alum;
        logic        pcsrc;
        logic        branch;
        logic        chk_pcb;
        logic [31:0] pcb;
        logic        rw;
        logic        mw;
        logic        as;
        logic [1:0]  rs;
        logic [3:0]  ac;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    localparam logic [31:0] NOP = 32'h00000013;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rv(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : model[idx];
    endfunction

    task automatic chk_e(input string nm, input logic rw, input logic mw, input logic as,
                         input logic [1:0] rs, input logic [3:0] ac, input logic ill,
                         input logic [31:0] imm, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] pcp4, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd);
        chk({nm, " ctrl"}, {22'd0, RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE, IllegalE},
            {22'd0, rw, mw, as, rs, ac, ill});
        chk({nm, " ImmExtE"}, ImmExtE, imm);
        chk({nm, " RD1E"}, RD1E, rd1);
        chk({nm, " RD2E"}, RD2E, rd2);
        chk({nm, " PCPlus4E"}, PCPlus4E, pcp4);
        chk({nm, " regidx"}, {17'd0, Rs1E, Rs2E, RdE}, {17'd0, r1, r2, rd});
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] val);
        InstrD    = NOP;
        RegWriteW = 1'b1;
        RdW       = r;
        ResultW   = val;
        tick();
        RegWriteW = 1'b0;
        if (r != 5'd0) model[r] = val;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        vecs[0]  = '{"add",     32'h00018233, 32'h00000100, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 32'h0,        1'b0};
        vecs[1]  = '{"sub",     32'h402084B3, 32'h00000104, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 2'b00, 4'd1, 32'h0,        1'b0};
        vecs[2]  = '{"sra",     32'h4020D4B3, 32'h00000108, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 2'b00, 4'd8, 32'h0,        1'b0};
        vecs[3]  = '{"slti",    32'hFFF0A513, 32'h0000010C, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 2'b00, 4'd5, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{"lw",      32'h00C12383, 32'h00000110, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 2'b01, 4'd0, 32'h0000000C, 1'b0};
        vecs[5]  = '{"sw",      32'hFE112E23, 32'h00000114, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 2'b00, 4'd0, 32'hFFFFFFFC, 1'b0};
        vecs[6]  = '{"lui",     32'hABCDE437, 32'h00000118, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 2'b00, 4'd9, 32'hABCDE000, 1'b0};
        vecs[7]  = '{"beq_t",   32'hFE208CE3, 32'h00000014, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h08,  1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 32'hFFFFFFF8, 1'b0};
        vecs[8]  = '{"bne_nt",  32'hFE209CE3, 32'h00000014, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h08,  1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 32'hFFFFFFF8, 1'b0};
        vecs[9]  = '{"beq_fwb", 32'hFE208CE3, 32'h00000014, 1'b0, 1'b1, 32'h8,   1'b0, 1'b1, 1'b1, 32'h08,  1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 32'hFFFFFFF8, 1'b0};
        vecs[10] = '{"blt_t",   32'h00134463, 32'h00000040, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h44,  1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 32'h00000008, 1'b0};
        vecs[11] = '{"bge_nt",  32'h00135463, 32'h00000040, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h44,  1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 32'h00000008, 1'b0};
        vecs[12] = '{"bltu_nt", 32'h00136463, 32'h00000040, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h44,  1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 32'h00000008, 1'b0};
        vecs[13] = '{"bgeu_t",  32'h00137463, 32'h00000040, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h44,  1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 32'h00000008, 1'b0};
        vecs[14] = '{"jal",     32'h010000EF, 32'h00000024, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h30,  1'b1, 1'b0, 1'b0, 2'b10, 4'd0, 32'h00000010, 1'b0};
        vecs[15] = '{"jalr_fw", 32'h00428067, 32'h00000050, 1'b1, 1'b0, 32'h101, 1'b1, 1'b0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 2'b10, 4'd0, 32'h00000004, 1'b0};
        vecs[16] = '{"jalr_odd",32'h00328067, 32'h00000054, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h202, 1'b1, 1'b0, 1'b0, 2'b10, 4'd0, 32'h00000003, 1'b0};
        vecs[17] = '{"ill_7f",  32'hFFFFFFFF, 32'h00000058, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 32'h0,        1'b1};
        vecs[18] = '{"ill_0f",  32'h0000000F, 32'h0000005C, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 32'h0,        1'b1};

        reset = 1'b1; InstrD = NOP; PCPlus4D = 32'd0; RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0;
        ForwardAD = 1'b0; ForwardBD = 1'b0; ALUResultM = 32'd0; FlushE = 1'b0;
        tick();
        tick();
        chk_e("reset", 0, 0, 0, 2'b00, 4'd0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        reset = 1'b0;

        // addi x1,x0,5 straight out of reset
        InstrD = 32'h00500093; PCPlus4D = 32'h8;
        tick();
        chk_e("addi", 1, 0, 1, 2'b00, 4'd0, 0, 32'd5, 32'd0, 32'd0, 32'h8, 5'd0, 5'd5, 5'd1);

        wr(5'd1, 32'd7);
        wr(5'd2, 32'd7);
        wr(5'd5, 32'h200);
        wr(5'd6, 32'hFFFFFFF0);

        // same-cycle write of x3 is visible to the read
        InstrD = 32'h00018233; RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hDEADBEEF;
        tick();
        model[3] = 32'hDEADBEEF;
        chk("wt_bypass RD1E", RD1E, 32'hDEADBEEF);
        InstrD = 32'h00000233; RdW = 5'd0; ResultW = 32'h12345678;
        tick();
        chk("x0_write RD1E", RD1E, 32'd0);
        RegWriteW = 1'b0;
        tick();
        chk("x0_after RD1E", RD1E, 32'd0);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            InstrD = v.instr; PCPlus4D = v.pcp4; ForwardAD = v.fwa; ForwardBD = v.fwb; ALUResultM = v.alum;
            #1;
            chk({v.name, " PCSrcD"}, {31'd0, PCSrcD}, {31'd0, v.pcsrc});
            chk({v.name, " BranchD"}, {31'd0, BranchD}, {31'd0, v.branch});
            chk({v.name, " RsD"}, {22'd0, Rs1D, Rs2D}, {22'd0, v.instr[19:15], v.instr[24:20]});
            if (v.chk_pcb) chk({v.name, " PCBranchD"}, PCBranchD, v.pcb);
            tick();
            chk_e(v.name, v.rw, v.mw, v.as, v.rs, v.ac, v.ill, v.imm,
                  rv(v.instr[19:15]), rv(v.instr[24:20]), v.pcp4,
                  v.instr[19:15], v.instr[24:20], v.instr[11:7]);
        end
        ForwardAD = 1'b0; ForwardBD = 1'b0; ALUResultM = 32'd0;

        // beq x1,x2 no longer taken once x2=8
        wr(5'd2, 32'd8);
        InstrD = 32'hFE208CE3; PCPlus4D = 32'h14;
        #1;
        chk("beq_x2_8 PCSrcD", {31'd0, PCSrcD}, 32'd0);
        chk("beq_x2_8 BranchD", {31'd0, BranchD}, 32'd1);
        tick();

        // flush bubbles E but the writeback still lands
        InstrD = 32'h00500093; PCPlus4D = 32'h60; FlushE = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd11; ResultW = 32'h55;
        tick();
        model[11] = 32'h55;
        chk_e("flush", 0, 0, 0, 2'b00, 4'd0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        FlushE = 1'b0; RegWriteW = 1'b0;
        InstrD = 32'h00058233; PCPlus4D = 32'h64;
        tick();
        chk("flush_write RD1E", RD1E, 32'h55);
        chk("flush_release RegWriteE", {31'd0, RegWriteE}, 32'd1);

        // reset mid-stream dominates a simultaneous write and flush
        InstrD = 32'h00500093; PCPlus4D = 32'h68; FlushE = 1'b1; reset = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h77;
        tick();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        chk_e("mid_reset", 0, 0, 0, 2'b00, 4'd0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        reset = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0;
        InstrD = 32'h00728233; PCPlus4D = 32'h6C;
        tick();
        chk("post_reset x5", RD1E, 32'd0);
        chk("post_reset x7", RD2E, 32'd0);
        chk("post_reset ctrl", {31'd0, RegWriteE}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
